// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit in front of the NPC decoder.
// Holds the PC and fetches one 32-bit word at a time over a req/gnt/rvalid
// port, with at most one request outstanding. Each word is presented to the
// decoder with its PC over a valid/ready handshake. Redirects from execute
// replace the PC and cancel any word still in flight.
// Optional feature: define IFU_EBREAK_HALT_EN to stop fetching once an ebreak
// (32'h0010_0073) has been handed to the decoder; only reset leaves the halt.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          XLEN     = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

`ifdef IFU_EBREAK_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fpc_q;
  logic            drop_q;
  logic            req_q;
  logic            inst_valid_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            halted_q;

  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_plus4;

  // Redirect targets are forced word aligned; sequential PC wraps modulo 2^XLEN.
  always_comb begin
    redirect_target = redirect_pc & ~XLEN'(3);
    pc_plus4        = pc_q + XLEN'(4);
  end

  // Fetch FSM with registered outputs. The request flag is its own register so
  // it stays low during reset and rises only after the first clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC[XLEN-1:0];
      fpc_q        <= RESET_PC[XLEN-1:0];
      drop_q       <= 1'b0;
      req_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= '0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_q && imem_gnt) begin
            fpc_q   <= pc_q;
            state_q <= ST_WAIT;
            req_q   <= 1'b0;
            if (redirect_valid) begin
              pc_q   <= redirect_target;
              drop_q <= 1'b1;
            end
          end else begin
            req_q <= 1'b1;
            if (redirect_valid) begin
              pc_q <= redirect_target;
            end
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc_q <= redirect_target;
            if (imem_rvalid) begin
              drop_q  <= 1'b0;
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end else begin
              inst_q       <= imem_rdata;
              inst_pc_q    <= fpc_q;
              inst_valid_q <= 1'b1;
              state_q      <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (redirect_valid) begin
            inst_valid_q <= 1'b0;
            pc_q         <= redirect_target;
            state_q      <= ST_REQ;
            req_q        <= 1'b1;
          end else if (inst_ready) begin
            inst_valid_q <= 1'b0;
`ifdef IFU_EBREAK_HALT_EN
            if (inst_q == EBREAK) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= pc_plus4;
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end
`else
            pc_q    <= pc_plus4;
            state_q <= ST_REQ;
            req_q   <= 1'b1;
`endif
          end
        end

`ifdef IFU_EBREAK_HALT_EN
        ST_HALT: begin
          req_q        <= 1'b0;
          inst_valid_q <= 1'b0;
          halted_q     <= 1'b1;
        end
`endif

        default: begin
          state_q      <= ST_REQ;
          req_q        <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    imem_req   = req_q;
    imem_addr  = pc_q;
    inst_valid = inst_valid_q;
    inst       = inst_q;
    inst_pc    = inst_pc_q;
`ifdef IFU_EBREAK_HALT_EN
    halted     = halted_q;
`else
    halted     = 1'b0;
`endif
  end

`ifndef IFU_EBREAK_HALT_EN
  // Without the halt feature the halt flag register is never used.
  logic unusedHalted;
  always_comb unusedHalted = halted_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed steps with a scoreboard queue of
// expected {inst, inst_pc} pairs pushed when a word is returned and popped when
// the decoder side handshakes.
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        rstn;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [95:0] scoreboard[$];
  logic [63:0] expPc;

  ifu_fetch #(.RESET_PC(RESET_PC), .XLEN(64)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts, and reports with tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s differs", tag);
    end
  endtask

  // Drive all DUT inputs at once, then advance to the next falling edge.
  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic redir, input logic [63:0] rpc, input logic ready);
    imem_gnt       = gnt;
    imem_rvalid    = rvalid;
    imem_rdata     = rdata;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = ready;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
  endtask

  // Wait (bounded) for a request and check its address against the model PC.
  task automatic waitReq(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      idle();
      n++;
    end
    checkOutput({tag, "_req"}, {63'h0, imem_req}, 64'h1);
    checkOutput({tag, "_addr"}, imem_addr, expPc);
  endtask

  // Grant the pending request, return data one cycle later, expect delivery.
  task automatic fetchOne(input string tag, input logic [31:0] data);
    waitReq(tag);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, data, 1'b0, 64'h0, 1'b0);
    scoreboard.push_back({data, expPc});
  endtask

  // Wait (bounded) for inst_valid, stall holdCycles, then accept and compare.
  task automatic acceptOne(input string tag, input int holdCycles);
    logic [95:0] e;
    int n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin
      idle();
      n++;
    end
    checkOutput({tag, "_valid"}, {63'h0, inst_valid}, 64'h1);
    e = (scoreboard.size() > 0) ? scoreboard.pop_front() : 96'h0;
    for (int i = 0; i < holdCycles; i++) begin
      idle();
      checkOutput({tag, "_hold_inst"}, {32'h0, inst}, {32'h0, e[95:64]});
      checkOutput({tag, "_hold_noreq"}, {63'h0, imem_req}, 64'h0);
    end
    checkOutput({tag, "_inst"}, {32'h0, inst}, {32'h0, e[95:64]});
    checkOutput({tag, "_pc"}, inst_pc, e[63:0]);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    checkOutput({tag, "_validdrop"}, {63'h0, inst_valid}, 64'h0);
    expPc = expPc + 64'd4;
    idle();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"}, {63'h0, imem_req}, 64'h0);
    checkOutput({tag, "_addr"}, imem_addr, RESET_PC);
    checkOutput({tag, "_ivalid"}, {63'h0, inst_valid}, 64'h0);
    checkOutput({tag, "_inst"}, {32'h0, inst}, 64'h0);
    checkOutput({tag, "_ipc"}, inst_pc, 64'h0);
    checkOutput({tag, "_halted"}, {63'h0, halted}, 64'h0);
  endtask

  initial begin
    rstn = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; inst_ready = 1'b0;
    expPc = RESET_PC;
    repeat (3) @(negedge clk);
    checkReset("reset");

    // Basic fetch after reset release.
    rstn = 1'b1;
    checkOutput("release_req_low", {63'h0, imem_req}, 64'h0);
    idle();
    fetchOne("t1", 32'h0010_0093);
    acceptOne("t1", 0);

    // Decoder stall for five cycles.
    fetchOne("t2", 32'h1234_5678);
    acceptOne("t2", 5);

    // Redirect while waiting for data: the returned word is dropped.
    waitReq("t3");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0103, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b1);
    checkOutput("t3_novalid", {63'h0, inst_valid}, 64'h0);
    idle();
    checkOutput("t3_novalid2", {63'h0, inst_valid}, 64'h0);
    expPc = 64'h8000_0100;
    fetchOne("t3b", 32'hAAAA_0001);
    acceptOne("t3b", 1);

    // Redirect in WAIT coinciding with rvalid.
    waitReq("t3c");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hBAD0_0001, 1'b1, 64'h8000_0180, 1'b1);
    checkOutput("t3c_novalid", {63'h0, inst_valid}, 64'h0);
    expPc = 64'h8000_0180;
    fetchOne("t3d", 32'hAAAA_0002);
    acceptOne("t3d", 0);

    // Redirect in the same cycle as the grant.
    waitReq("t4");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 64'h8000_0200, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_novalid", {63'h0, inst_valid}, 64'h0);
    expPc = 64'h8000_0200;
    fetchOne("t4b", 32'hAAAA_0003);
    acceptOne("t4b", 0);

    // Redirect in HOLD together with a handshake.
    fetchOne("th", 32'hAAAA_0004);
    begin
      logic [95:0] e;
      int n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin
        idle();
        n++;
      end
      e = (scoreboard.size() > 0) ? scoreboard.pop_front() : 96'h0;
      checkOutput("th_inst", {32'h0, inst}, {32'h0, e[95:64]});
      checkOutput("th_pc", inst_pc, e[63:0]);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0300, 1'b1);
      checkOutput("th_validdrop", {63'h0, inst_valid}, 64'h0);
    end
    expPc = 64'h8000_0300;
    waitReq("th_next");

    // Back-to-back redirects in REQ: the last one wins.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0400, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0500, 1'b0);
    expPc = 64'h8000_0500;
    waitReq("b2b");

    // Wrap-around at the top of the address space; low bits are forced to 0.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    expPc = 64'hFFFF_FFFF_FFFF_FFFC;
    fetchOne("wrap", 32'hAAAA_0005);
    acceptOne("wrap", 0);
    waitReq("wrap_next");
    checkOutput("wrap_zero", imem_addr, 64'h0);

    // ebreak handling.
    fetchOne("eb", 32'h0010_0073);
    acceptOne("eb", 0);
`ifdef IFU_EBREAK_HALT_EN
    checkOutput("eb_halted", {63'h0, halted}, 64'h1);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 64'h8000_0600, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle();
      checkOutput("eb_noreq", {63'h0, imem_req}, 64'h0);
      checkOutput("eb_novalid", {63'h0, inst_valid}, 64'h0);
      checkOutput("eb_stay", {63'h0, halted}, 64'h1);
    end
    rstn = 1'b0;
    #1;
    checkReset("eb_reset");
    @(negedge clk);
    rstn = 1'b1;
    expPc = RESET_PC;
    waitReq("eb_restart");
`else
    checkOutput("eb_nohalt", {63'h0, halted}, 64'h0);
    waitReq("eb_next");
`endif

    // Reset mid-operation, with a stray rvalid after release.
    expPc = imem_addr;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    checkReset("midreset");
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 64'h0, 1'b1);
    checkOutput("midreset_novalid", {63'h0, inst_valid}, 64'h0);
    expPc = RESET_PC;
    fetchOne("after", 32'hAAAA_0006);
    acceptOne("after", 0);

    checkOutput("sb_empty", 64'(scoreboard.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
